// File: rtl/apb_req_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : apb_req_arbiter
//  Description : APB master-side controller that shares one APB target
//                between two requesters. Requests are arbitrated round-robin.
//                The winning command is latched at grant. The controller then
//                runs the APB SETUP/ACCESS phases and waits on pready. Read
//                data and slave error go back to the granted requester with a
//                one-cycle, one-hot done strobe.
//
//  Ports       : pclk, presetn         - clock, async active-low reset
//                req[1:0]              - per-requester request (level)
//                req_wr[1:0]           - per-requester direction (1 = write)
//                req_addr/wdata/strb   - packed per-requester command
//                done[1:0]             - one-hot completion to granted side
//                rsp_rdata, rsp_err    - response, valid while done != 0
//                busy                  - transfer in progress
//                psel/penable/pwrite/paddr/pwdata/pstrb - APB master outputs
//                pready/prdata/pslverr - APB slave response
//
//  Options     : APB_TIMEOUT_EN - when defined, an ACCESS phase that lasts
//                TIMEOUT cycles without pready is ended with rsp_err = 1.
//                When undefined, ACCESS waits indefinitely for pready.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_req_arbiter #(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                    pclk,
   input  logic                    presetn,
   // requester side
   input  logic [1:0]              req,
   input  logic [1:0]              req_wr,
   input  logic [2*ADDR_W-1:0]     req_addr,
   input  logic [2*DATA_W-1:0]     req_wdata,
   input  logic [2*DATA_W/8-1:0]   req_strb,
   output logic [1:0]              done,
   output logic [DATA_W-1:0]       rsp_rdata,
   output logic                    rsp_err,
   output logic                    busy,
   // APB master side
   output logic                    psel,
   output logic                    penable,
   output logic                    pwrite,
   output logic [ADDR_W-1:0]       paddr,
   output logic [DATA_W-1:0]       pwdata,
   output logic [DATA_W/8-1:0]     pstrb,
   input  logic                    pready,
   input  logic [DATA_W-1:0]       prdata,
   input  logic                    pslverr
);

   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   state_t r_state;
   logic   r_last_gnt;   // index of the requester granted most recently
   logic   r_gnt;        // index of the requester owning the current transfer

   // ------------------------------------------------------------------------
   // Arbitration: a lone requester wins outright; on contention the one that
   // was not served last wins.
   // ------------------------------------------------------------------------
   logic              w_gnt;
   logic              w_wr;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;
   logic [STRB_W-1:0] w_strb;

   always_comb begin
      w_gnt = ~r_last_gnt;
      case (req)
         2'b01:   w_gnt = 1'b0;
         2'b10:   w_gnt = 1'b1;
         default: w_gnt = ~r_last_gnt;
      endcase
   end

   assign w_wr    = w_gnt ? req_wr[1] : req_wr[0];
   assign w_addr  = w_gnt ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
   assign w_wdata = w_gnt ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
   assign w_strb  = w_gnt ? req_strb[2*STRB_W-1:STRB_W]  : req_strb[STRB_W-1:0];

   // ------------------------------------------------------------------------
   // Optional ACCESS-phase watchdog. The counter is cleared in SETUP, so it
   // holds 0 in the first ACCESS cycle. It reaches TIMEOUT-1 in the
   // TIMEOUT-th ACCESS cycle, and that cycle ends the transfer unless pready
   // arrives in it.
   // ------------------------------------------------------------------------
   logic w_timeout;

`ifdef APB_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   logic [TMO_W-1:0] r_tmo_cnt;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_tmo_cnt <= '0;
      end else if (r_state == ST_SETUP) begin
         r_tmo_cnt <= '0;
      end else if ((r_state == ST_ACCESS) && !pready) begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end

   assign w_timeout = (r_state == ST_ACCESS) && !pready &&
                      (r_tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
   assign w_timeout = 1'b0;
`endif

   // A transfer ends on pready, or on the watchdog when it is enabled.
   logic w_xfer_end;
   assign w_xfer_end = (r_state == ST_ACCESS) && (pready || w_timeout);

   // ------------------------------------------------------------------------
   // Completion / response. These are combinational, so they are valid in
   // the ACCESS cycle that sees pready. A normal completion reports
   // pslverr. A timeout always reports an error and returns zero data.
   // ------------------------------------------------------------------------
   assign done      = w_xfer_end ? (r_gnt ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_rdata = ((r_state == ST_ACCESS) && pready && !pwrite) ? prdata
                                                                    : '0;
   assign rsp_err   = (r_state == ST_ACCESS) && (pready ? pslverr : w_timeout);
   assign busy      = (r_state != ST_IDLE);

   // ------------------------------------------------------------------------
   // Control FSM with registered APB outputs. The command is captured only
   // in IDLE, so the requester inputs are ignored for the rest of a transfer.
   // ------------------------------------------------------------------------
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_state    <= ST_IDLE;
         r_last_gnt <= 1'b1;      // requester 0 wins the first contention
         r_gnt      <= 1'b0;
         psel       <= 1'b0;
         penable    <= 1'b0;
         pwrite     <= 1'b0;
         paddr      <= '0;
         pwdata     <= '0;
         pstrb      <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (|req) begin
                  r_gnt      <= w_gnt;
                  r_last_gnt <= w_gnt;
                  pwrite     <= w_wr;
                  paddr      <= w_addr;
                  // Reads put zero data and strobes on the bus.
                  pwdata     <= w_wr ? w_wdata : '0;
                  pstrb      <= w_wr ? w_strb  : '0;
                  psel       <= 1'b1;
                  penable    <= 1'b0;
                  r_state    <= ST_SETUP;
               end
            end

            ST_SETUP: begin
               penable <= 1'b1;
               r_state <= ST_ACCESS;
            end

            ST_ACCESS: begin
               // Every APB output holds its value until the transfer ends.
               if (w_xfer_end) begin
                  psel    <= 1'b0;
                  penable <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end

            default: begin
               psel    <= 1'b0;
               penable <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_apb_req_arbiter
//  Description : Self-checking bench for apb_req_arbiter. It includes a small
//                APB slave model with a programmable number of wait states,
//                stuck-ready, forced-ready, read data and error. Expected
//                completions are queued when a request is issued. A monitor
//                pops one entry and compares it on every done strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_req_arbiter;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;
   localparam int STRB_W = DATA_W / 8;

   logic                  pclk    = 1'b0;
   logic                  presetn = 1'b0;
   logic [1:0]            req     = '0;
   logic [1:0]            req_wr  = '0;
   logic [2*ADDR_W-1:0]   req_addr  = '0;
   logic [2*DATA_W-1:0]   req_wdata = '0;
   logic [2*STRB_W-1:0]   req_strb  = '0;
   logic [1:0]            done;
   logic [DATA_W-1:0]     rsp_rdata;
   logic                  rsp_err;
   logic                  busy;
   logic                  psel, penable, pwrite;
   logic [ADDR_W-1:0]     paddr;
   logic [DATA_W-1:0]     pwdata;
   logic [STRB_W-1:0]     pstrb;
   logic                  pready;
   logic [DATA_W-1:0]     prdata;
   logic                  pslverr;

   apb_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(16)) dut (
      .pclk(pclk), .presetn(presetn),
      .req(req), .req_wr(req_wr), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_strb(req_strb),
      .done(done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .pstrb(pstrb),
      .pready(pready), .prdata(prdata), .pslverr(pslverr)
   );

   always #5 pclk = ~pclk;

   // ---------------- APB slave model ----------------
   int                slv_wait      = 0;
   logic              slv_stuck     = 1'b0;
   logic              slv_force_rdy = 1'b0;
   logic [DATA_W-1:0] slv_rdata     = '0;
   logic              slv_err       = 1'b0;
   int                acc_cnt       = 0;

   always @(posedge pclk) begin
      if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
      else if (!(psel && penable))    acc_cnt <= 0;
   end

   assign pready  = slv_force_rdy |
                    (psel && penable && !slv_stuck && (acc_cnt >= slv_wait));
   assign prdata  = slv_rdata;
   assign pslverr = slv_err;

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [1:0]        done;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] rdata;
      logic              err;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic push_exp(input logic [1:0] d, input logic wr,
                           input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] rd, input logic er);
      exp_t e;
      e.done = d; e.wr = wr; e.addr = a; e.rdata = rd; e.err = er;
      sb.push_back(e);
   endtask

   always @(negedge pclk) begin
      if (presetn && (done !== 2'b00)) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected_done: done=%b paddr=%h, nothing expected",
                     done, paddr);
         end else begin
            mon_e = sb.pop_front();
            if (done !== mon_e.done || rsp_rdata !== mon_e.rdata ||
                rsp_err !== mon_e.err || paddr !== mon_e.addr ||
                pwrite !== mon_e.wr) begin
               n_fail++;
               $display("FAIL sb_completion: got done=%b addr=%h wr=%b rdata=%h err=%b, want done=%b addr=%h wr=%b rdata=%h err=%b",
                        done, paddr, pwrite, rsp_rdata, rsp_err,
                        mon_e.done, mon_e.addr, mon_e.wr, mon_e.rdata, mon_e.err);
            end
         end
      end
   end

   // Waits up to budget cycles for done[idx] and counts penable cycles on the way.
   task automatic wait_done(input int idx, input int budget,
                            output bit got, output int pen);
      got = 1'b0;
      pen = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge pclk);
         if (penable) pen++;
         if (done[idx]) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   task automatic drive_edge();
      @(posedge pclk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      presetn = 1'b0;
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      n_checks++;
      if ({psel, penable, pwrite, busy} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ctrl: psel/pen/pwrite/busy=%b, want 0000",
                  {psel, penable, pwrite, busy});
      end
      n_checks++;
      if (paddr !== '0 || pwdata !== '0 || pstrb !== '0) begin
         n_fail++;
         $display("FAIL reset_bus: paddr=%h pwdata=%h pstrb=%h, want 0",
                  paddr, pwdata, pstrb);
      end
      n_checks++;
      if (done !== 2'b00 || rsp_err !== 1'b0 || rsp_rdata !== '0) begin
         n_fail++;
         $display("FAIL reset_rsp: done=%b err=%b rdata=%h, want 0",
                  done, rsp_err, rsp_rdata);
      end
      drive_edge();
      presetn = 1'b1;
   endtask

   task automatic test_write();
      drive_edge();
      slv_wait = 0;
      req_wr[0] = 1'b1;
      req_addr[ADDR_W-1:0] = 12'h004;
      req_wdata[DATA_W-1:0] = 32'hA5A5_0001;
      req_strb[STRB_W-1:0] = 4'hF;
      push_exp(2'b01, 1'b1, 12'h004, 32'h0, 1'b0);
      req[0] = 1'b1;
      @(negedge pclk);
      n_checks++;
      if (psel !== 1'b0) begin
         n_fail++;
         $display("FAIL write_psel_early: psel=%b, want 0", psel);
      end
      @(negedge pclk);
      n_checks++;
      if (psel !== 1'b1 || penable !== 1'b0 || busy !== 1'b1 || pwrite !== 1'b1 ||
          paddr !== 12'h004 || pwdata !== 32'hA5A5_0001 || pstrb !== 4'hF) begin
         n_fail++;
         $display("FAIL write_setup: psel=%b pen=%b busy=%b pwrite=%b paddr=%h pwdata=%h pstrb=%h, want 1 0 1 1 004 a5a50001 f",
                  psel, penable, busy, pwrite, paddr, pwdata, pstrb);
      end
      @(negedge pclk);
      n_checks++;
      if (penable !== 1'b1 || done !== 2'b01) begin
         n_fail++;
         $display("FAIL write_access: penable=%b done=%b, want 1 01", penable, done);
      end
      drive_edge();
      req[0] = 1'b0;
      @(negedge pclk);
      n_checks++;
      if (psel !== 1'b0 || penable !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL write_release: psel=%b pen=%b busy=%b, want 000",
                  psel, penable, busy);
      end
   endtask

   task automatic test_read_wait();
      bit got;
      int pen;
      drive_edge();
      slv_wait = 3;
      slv_rdata = 32'h1234_5678;
      req_wr[1] = 1'b0;
      req_addr[2*ADDR_W-1:ADDR_W] = 12'h008;
      req_wdata[2*DATA_W-1:DATA_W] = 32'hDEAD_BEEF;
      req_strb[2*STRB_W-1:STRB_W] = 4'hF;
      push_exp(2'b10, 1'b0, 12'h008, 32'h1234_5678, 1'b0);
      req[1] = 1'b1;
      @(negedge pclk);
      @(negedge pclk);   // SETUP cycle
      n_checks++;
      if (psel !== 1'b1 || pstrb !== 4'h0 || pwdata !== 32'h0) begin
         n_fail++;
         $display("FAIL read_bus_masked: psel=%b pstrb=%h pwdata=%h, want 1 0 0",
                  psel, pstrb, pwdata);
      end
      wait_done(1, 20, got, pen);
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL read_done_timeout: done[1] not seen, want within 20 cycles");
      end
      n_checks++;
      if (pen !== 4) begin
         n_fail++;
         $display("FAIL read_penable_len: penable cycles=%0d, want 4", pen);
      end
      drive_edge();
      req[1] = 1'b0;
      slv_wait = 0;
   endtask

   task automatic test_contention();
      int dc[$];
      int idle_cnt;
      drive_edge();
      slv_wait = 0;
      slv_rdata = 32'hCAFE_0001;
      req_wr = 2'b01;
      req_addr = {12'h200, 12'h100};
      req_wdata[DATA_W-1:0] = 32'h1111_1111;
      req_strb[STRB_W-1:0] = 4'h3;
      // requester 1 was served last, so requester 0 goes first
      for (int k = 0; k < 2; k++) begin
         push_exp(2'b01, 1'b1, 12'h100, 32'h0, 1'b0);
         push_exp(2'b10, 1'b0, 12'h200, 32'hCAFE_0001, 1'b0);
      end
      req = 2'b11;
      idle_cnt = 0;
      for (int i = 0; i < 40 && dc.size() < 4; i++) begin
         @(negedge pclk);
         if (dc.size() > 0 && !psel) idle_cnt++;
         if (done !== 2'b00) dc.push_back(i);
      end
      drive_edge();
      req = 2'b00;
      n_checks++;
      if (dc.size() != 4) begin
         n_fail++;
         $display("FAIL contention_count: dones=%0d, want 4", dc.size());
      end else begin
         for (int g = 0; g < 3; g++) begin
            n_checks++;
            if (dc[g+1] - dc[g] !== 3) begin
               n_fail++;
               $display("FAIL contention_spacing: gap %0d = %0d cycles, want 3",
                        g, dc[g+1] - dc[g]);
            end
         end
      end
      n_checks++;
      if (idle_cnt !== 3) begin
         n_fail++;
         $display("FAIL contention_idle: idle cycles=%0d, want 3", idle_cnt);
      end
   endtask

   task automatic test_error();
      bit got;
      int pen;
      drive_edge();
      slv_force_rdy = 1'b1;   // pready/pslverr high while idle must be ignored
      slv_err = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge pclk);
         n_checks++;
         if (done !== 2'b00 || rsp_err !== 1'b0 || psel !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ignore: done=%b err=%b psel=%b, want 00 0 0",
                     done, rsp_err, psel);
         end
      end
      drive_edge();
      slv_force_rdy = 1'b0;
      req_wr[0] = 1'b1;
      req_addr[ADDR_W-1:0] = 12'h040;
      push_exp(2'b01, 1'b1, 12'h040, 32'h0, 1'b1);
      req[0] = 1'b1;
      wait_done(0, 20, got, pen);
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL error_done_timeout: done[0] not seen, want within 20 cycles");
      end
      drive_edge();
      req[0] = 1'b0;
      slv_err = 1'b0;
      drive_edge();
      push_exp(2'b01, 1'b1, 12'h040, 32'h0, 1'b0);
      req[0] = 1'b1;
      wait_done(0, 20, got, pen);
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL error_clear_timeout: done[0] not seen, want within 20 cycles");
      end
      drive_edge();
      req[0] = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit got;
      int pen;
      bit in_access;
      drive_edge();
      slv_wait = 1000;
      req_wr = 2'b01;
      req_addr = {12'h0F4, 12'h0F0};
      req[0] = 1'b1;
      in_access = 1'b0;
      for (int i = 0; i < 10 && !in_access; i++) begin
         @(negedge pclk);
         if (penable) in_access = 1'b1;
      end
      n_checks++;
      if (!in_access) begin
         n_fail++;
         $display("FAIL rstmid_access_timeout: penable not seen, want within 10 cycles");
      end
      @(negedge pclk);
      #2;
      presetn = 1'b0;
      #1;
      n_checks++;
      if (psel !== 1'b0 || penable !== 1'b0 || busy !== 1'b0 || done !== 2'b00) begin
         n_fail++;
         $display("FAIL rstmid_async: psel=%b pen=%b busy=%b done=%b, want 0 0 0 00",
                  psel, penable, busy, done);
      end
      slv_wait = 0;
      req = 2'b11;
      drive_edge();
      drive_edge();
      push_exp(2'b01, 1'b1, 12'h0F0, 32'h0, 1'b0);
      presetn = 1'b1;
      wait_done(0, 20, got, pen);
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL rstmid_first_grant: done[0] not seen, want requester 0 first");
      end
      drive_edge();
      req = 2'b00;
   endtask

   task automatic test_stuck();
      bit got;
      int pen;
      drive_edge();
      slv_stuck = 1'b1;
      slv_rdata = 32'h5555_AAAA;
      req_wr[0] = 1'b0;
      req_addr[ADDR_W-1:0] = 12'h010;
`ifdef APB_TIMEOUT_EN
      push_exp(2'b01, 1'b0, 12'h010, 32'h0, 1'b1);
      req[0] = 1'b1;
      wait_done(0, 60, got, pen);
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL stuck_timeout_done: done[0] not seen, want within 60 cycles");
      end
      n_checks++;
      if (pen !== 16) begin
         n_fail++;
         $display("FAIL stuck_timeout_len: ACCESS cycles=%0d, want 16", pen);
      end
      drive_edge();
      req[0] = 1'b0;
      @(negedge pclk);
      n_checks++;
      if (psel !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL stuck_timeout_idle: psel=%b busy=%b, want 0 0", psel, busy);
      end
      slv_stuck = 1'b0;
`else
      req[0] = 1'b1;
      wait_done(0, 100, got, pen);
      n_checks++;
      if (got) begin
         n_fail++;
         $display("FAIL stuck_no_done: done[0] seen, want none after 100 cycles");
      end
      n_checks++;
      if (psel !== 1'b1 || penable !== 1'b1) begin
         n_fail++;
         $display("FAIL stuck_hold: psel=%b pen=%b, want 1 1", psel, penable);
      end
      drive_edge();
      presetn = 1'b0;
      req[0] = 1'b0;
      slv_stuck = 1'b0;
      drive_edge();
      presetn = 1'b1;
`endif
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write();
      test_read_wait();
      test_contention();
      test_error();
      test_reset_mid();
      test_stuck();
      repeat (3) @(negedge pclk);
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_leftover: %0d expected completions never seen, want 0",
                  sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
